// File: rtl/mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// mode_ctrl_if
// Front-panel bundle between the board keys / CPU halt flag and the mode
// controller, plus the controller's outputs towards program memory and CPU.
//
//   key_mode_n  raw mode push-button, active-low
//   key_step_n  raw step push-button, active-low
//   cpu_halt    CPU halt flag (level)
//   cpustate    00 IDLE, 01 IN, 10 CHECK, 11 RUN
//   step_n      debounced step level to memory A1, active-low
//   mem_rst_n   one-cycle active-low clear of memory entry counter
//   cpu_rst_n   one-cycle active-low CPU reset
//   run_en      CPU may execute
//   mode_led    one-hot {RUN,CHECK,IN,IDLE}
//
// master: panel / CPU side (drives keys and halt)
// slave : mode_ctrl (drives status and control outputs)
// ---------------------------------------------------------------------------
interface mode_ctrl_if;
    logic       key_mode_n;
    logic       key_step_n;
    logic       cpu_halt;
    logic [1:0] cpustate;
    logic       step_n;
    logic       mem_rst_n;
    logic       cpu_rst_n;
    logic       run_en;
    logic [3:0] mode_led;

    modport master (
        output key_mode_n, key_step_n, cpu_halt,
        input  cpustate, step_n, mem_rst_n, cpu_rst_n, run_en, mode_led
    );

    modport slave (
        input  key_mode_n, key_step_n, cpu_halt,
        output cpustate, step_n, mem_rst_n, cpu_rst_n, run_en, mode_led
    );
endinterface

// File: rtl/mode_ctrl.sv
// ---------------------------------------------------------------------------
// mode_ctrl
// Front-panel mode controller. Debounces the mode and step keys and walks
// the machine IDLE -> IN -> CHECK -> RUN -> IDLE on each mode-key press.
// Drives memory cpustate / A1 step / entry-counter clear, and CPU run enable
// and reset. All outputs are registered.
//
// Ports:
//   clk    divided system clock, rising edge
//   reset  synchronous, active-high
//   bus    mode_ctrl_if.slave (keys, cpu_halt in; cpustate, step_n,
//          mem_rst_n, cpu_rst_n, run_en, mode_led out)
// ---------------------------------------------------------------------------
module mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,   // >= 2
    parameter int CNT_W           = 5     // must hold DEBOUNCE_CYCLES-1
) (
    input  logic       clk,
    input  logic       reset,
    mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IN    = 2'b01,
        ST_CHECK = 2'b10,
        ST_RUN   = 2'b11
    } state_t;

    localparam int               KEY_MODE = 0;
    localparam int               KEY_STEP = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Debounce state, one lane per key: [KEY_STEP, KEY_MODE]
    logic [1:0]            w_key_raw;
    logic [1:0]            w_key_accept;
    logic [1:0]            w_key_stable_nxt;
    logic [1:0]            r_key_stable;
    logic [1:0][CNT_W-1:0] r_key_cnt;
    logic                  w_mode_press;

    // FSM and registered outputs
    state_t     r_state;
    logic [3:0] r_mode_led;
    logic       r_step_n;
    logic       r_mem_rst_n;
    logic       r_cpu_rst_n;
    logic       r_run_en;
    logic       r_step_mask;   // second cycle of the step_n hold after a transition
    logic       r_halted;      // sticky halt seen during the current RUN visit

    // Raw levels feed the counters directly so the accept edge lands exactly
    // DEBOUNCE_CYCLES edges after the key settles.
    assign w_key_raw = {bus.key_step_n, bus.key_mode_n};

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise paths
        // that skip an assignment infer a latch.
        w_key_accept     = '0;
        w_key_stable_nxt = r_key_stable;
        for (int k = 0; k < 2; k++) begin
            if ((w_key_raw[k] != r_key_stable[k]) && (r_key_cnt[k] == CNT_LAST)) begin
                w_key_accept[k]     = 1'b1;
                w_key_stable_nxt[k] = w_key_raw[k];
            end
        end
    end

    // Press = accepted stable 1->0 on the mode key, valid for exactly the edge
    // that updates the stable level. Releases are ignored.
    assign w_mode_press = w_key_accept[KEY_MODE] & ~w_key_raw[KEY_MODE];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_stable <= 2'b11;
            r_key_cnt    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            r_key_stable <= w_key_stable_nxt;
            for (int k = 0; k < 2; k++) begin
                if ((w_key_raw[k] == r_key_stable[k]) || w_key_accept[k])
                    r_key_cnt[k] <= '0;
                else
                    r_key_cnt[k] <= r_key_cnt[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode_led  <= 4'b0001;
            r_step_n    <= 1'b1;
            r_mem_rst_n <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_run_en    <= 1'b0;
            r_step_mask <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_mem_rst_n <= 1'b1;
            r_cpu_rst_n <= 1'b1;
            if (w_mode_press) begin
                // Hold step_n high on the transition and the cycle after, so a
                // step key held across the mode change cannot look like a fresh
                // A1 falling edge in the new state. Mode wins over a
                // simultaneous step edge for the same reason.
                r_step_n    <= 1'b1;
                r_step_mask <= 1'b1;
                r_run_en    <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_state     <= ST_IN;
                        r_mode_led  <= 4'b0010;
                        r_mem_rst_n <= 1'b0;
                    end
                    ST_IN: begin
                        r_state     <= ST_CHECK;
                        r_mode_led  <= 4'b0100;
                        r_mem_rst_n <= 1'b0;
                    end
                    ST_CHECK: begin
                        r_state     <= ST_RUN;
                        r_mode_led  <= 4'b1000;
                        r_cpu_rst_n <= 1'b0;
                        r_halted    <= 1'b0;
                    end
                    ST_RUN: begin
                        r_state    <= ST_IDLE;
                        r_mode_led <= 4'b0001;
                    end
                endcase
            end else begin
                r_step_mask <= 1'b0;
                if (r_step_mask || !((r_state == ST_IN) || (r_state == ST_CHECK)))
                    r_step_n <= 1'b1;
                else
                    r_step_n <= w_key_stable_nxt[KEY_STEP];

                // run_en rises one cycle after RUN entry (CPU reset cycle) and
                // a halt latches it off for the rest of this RUN visit.
                if ((r_state == ST_RUN) && !bus.cpu_halt && !r_halted)
                    r_run_en <= 1'b1;
                else
                    r_run_en <= 1'b0;
                if ((r_state == ST_RUN) && bus.cpu_halt)
                    r_halted <= 1'b1;
            end
        end
    end

    assign bus.cpustate  = r_state;
    assign bus.mode_led  = r_mode_led;
    assign bus.step_n    = r_step_n;
    assign bus.mem_rst_n = r_mem_rst_n;
    assign bus.cpu_rst_n = r_cpu_rst_n;
    assign bus.run_en    = r_run_en;

endmodule

// File: tb/tb_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mode_ctrl
// Self-checking bench for mode_ctrl with DEBOUNCE_CYCLES=4. A behavioural
// model tracks how long each raw key level has been held, the mode visited,
// cycles since the last mode change and whether a halt was seen in RUN, and
// predicts all outputs after every rising edge. Directed scenarios add
// explicit timing checks; a random phase exercises keys, halt and reset.
// ---------------------------------------------------------------------------
module tb_mode_ctrl;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mode_ctrl_if bus ();

    mode_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int         m_mode;          // 0 IDLE, 1 IN, 2 CHECK, 3 RUN
    bit         m_mode_stable;
    bit         m_step_stable;
    bit         last_mode_raw, last_step_raw;
    int         run_mode, run_step; // edges the current raw level has been seen
    int         m_since;         // edges since last mode change (0 = this edge)
    bit         m_halt_seen;
    logic [9:0] m_vec;           // {cpustate, mode_led, step_n, mem_rst_n, cpu_rst_n, run_en}

    task automatic model_edge();
        bit mk, sk, press, exp_step, exp_mem, exp_cpu, exp_run;
        int prev;
        mk    = bus.key_mode_n;
        sk    = bus.key_step_n;
        press = 1'b0;
        if (reset) begin
            m_mode        = 0;
            m_mode_stable = 1'b1;
            m_step_stable = 1'b1;
            last_mode_raw = mk;
            last_step_raw = sk;
            run_mode      = 0;
            run_step      = 0;
            m_since       = 100;
            m_halt_seen   = 1'b0;
            m_vec         = {2'b00, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
            return;
        end
        if (mk == last_mode_raw) run_mode++; else begin last_mode_raw = mk; run_mode = 1; end
        if (sk == last_step_raw) run_step++; else begin last_step_raw = sk; run_step = 1; end
        // A level held for D sampled edges, different from the stable level, is accepted.
        if (mk != m_mode_stable && run_mode >= D) begin
            press         = (mk == 1'b0);
            m_mode_stable = mk;
        end
        if (sk != m_step_stable && run_step >= D) m_step_stable = sk;
        prev = m_mode;
        if (press) begin
            m_mode  = (m_mode + 1) % 4;
            m_since = 0;
            if (m_mode == 3) m_halt_seen = 1'b0;
        end else begin
            if (m_since < 100) m_since++;
            if (prev == 3 && bus.cpu_halt) m_halt_seen = 1'b1;
        end
        exp_step = ((m_mode == 1 || m_mode == 2) && m_since >= 2) ? m_step_stable : 1'b1;
        exp_mem  = !(press && (m_mode == 1 || m_mode == 2));
        exp_cpu  = !(press && m_mode == 3);
        exp_run  = (m_mode == 3) && !press && !m_halt_seen;
        m_vec    = {2'(m_mode), 4'(1 << m_mode), exp_step, exp_mem, exp_cpu, exp_run};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [9:0] dut_vec();
        return {bus.cpustate, bus.mode_led, bus.step_n, bus.mem_rst_n, bus.cpu_rst_n, bus.run_en};
    endfunction

    // Navigation only: one clean mode press; the model keeps tracking.
    task automatic press_mode_quiet();
        bus.key_mode_n = 1'b0;
        repeat (D + 2) tick();
        bus.key_mode_n = 1'b1;
        repeat (D + 2) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.key_mode_n = 1'($urandom_range(1));
            bus.key_step_n = 1'($urandom_range(1));
            tick();
            checks++;
            if (dut_vec() !== m_vec) begin
                errors++; $display("FAIL reset_hold cyc %0d got %b exp %b", i, dut_vec(), m_vec);
            end
            checks++;
            if (bus.mem_rst_n !== 1'b0 || bus.cpu_rst_n !== 1'b0 || bus.mode_led !== 4'b0001) begin
                errors++; $display("FAIL reset_values got mem %b cpu %b led %b exp 0 0 0001",
                                   bus.mem_rst_n, bus.cpu_rst_n, bus.mode_led);
            end
        end
        bus.key_mode_n = 1'b1;
        bus.key_step_n = 1'b1;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.mem_rst_n !== 1'b1 || bus.cpu_rst_n !== 1'b1 || bus.cpustate !== 2'b00 || bus.run_en !== 1'b0) begin
            errors++; $display("FAIL reset_release got mem %b cpu %b st %b run %b exp 1 1 00 0",
                               bus.mem_rst_n, bus.cpu_rst_n, bus.cpustate, bus.run_en);
        end
    endtask

    task automatic test_debounce_mode();
        int tr;
        bus.key_mode_n = 1'b0;
        repeat (3) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL glitch_vec got %b exp %b", dut_vec(), m_vec); end
        end
        bus.key_mode_n = 1'b1;
        repeat (6) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL glitch_vec got %b exp %b", dut_vec(), m_vec); end
        end
        checks++;
        if (bus.cpustate !== 2'b00) begin errors++; $display("FAIL glitch_state got %b exp 00", bus.cpustate); end
        bus.key_mode_n = 1'b0;
        tr = 0;
        for (int i = 1; i <= 6; i++) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL press_vec cyc %0d got %b exp %b", i, dut_vec(), m_vec); end
            if (tr == 0 && bus.cpustate == 2'b01) begin
                tr = i;
                checks++;
                if (bus.mem_rst_n !== 1'b0) begin errors++; $display("FAIL enter_in_memrst got %b exp 0", bus.mem_rst_n); end
            end
        end
        checks++;
        if (tr != D) begin errors++; $display("FAIL press_latency got %0d exp %0d", tr, D); end
        bus.key_mode_n = 1'b1;
        repeat (D + 2) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL release_vec got %b exp %b", dut_vec(), m_vec); end
        end
    endtask

    task automatic test_step();
        int fall, rise;
        bus.key_step_n = 1'b0;
        fall = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL step_low_vec got %b exp %b", dut_vec(), m_vec); end
            if (fall == 0 && bus.step_n == 1'b0) fall = i;
        end
        bus.key_step_n = 1'b1;
        rise = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL step_high_vec got %b exp %b", dut_vec(), m_vec); end
            if (rise == 0 && bus.step_n == 1'b1) rise = i;
        end
        checks++;
        if (fall != D || rise != D) begin
            errors++; $display("FAIL step_latency got fall %0d rise %0d exp %0d", fall, rise, D);
        end
        // Low press with a 2-cycle bounce high after step_n has fallen.
        for (int i = 0; i < 12; i++) begin
            bus.key_step_n = (i == 5 || i == 6);
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL bounce_vec cyc %0d got %b exp %b", i, dut_vec(), m_vec); end
            if (i >= D - 1) begin
                checks++;
                if (bus.step_n !== 1'b0) begin errors++; $display("FAIL bounce_hold cyc %0d got %b exp 0", i, bus.step_n); end
            end
        end
        bus.key_step_n = 1'b1;
        repeat (D + 2) tick();
    endtask

    task automatic test_mode_cycle();
        int tr, exp_state;
        logic [1:0] prev_state;
        for (int p = 0; p < 3; p++) begin
            exp_state  = (p + 2) % 4;
            prev_state = bus.cpustate;
            bus.key_mode_n = 1'b0;
            tr = 0;
            for (int i = 1; i <= D + 2; i++) begin
                tick(); checks++;
                if (dut_vec() !== m_vec) begin errors++; $display("FAIL cycle_vec p %0d cyc %0d got %b exp %b", p, i, dut_vec(), m_vec); end
                if (tr == 0 && bus.cpustate !== prev_state) begin
                    tr = i;
                    if (p == 1) begin
                        checks++;
                        if (bus.cpu_rst_n !== 1'b0 || bus.run_en !== 1'b0) begin
                            errors++; $display("FAIL enter_run got cpu_rst_n %b run_en %b exp 0 0", bus.cpu_rst_n, bus.run_en);
                        end
                    end
                    if (p == 2) begin
                        checks++;
                        if (bus.run_en !== 1'b0) begin errors++; $display("FAIL leave_run got run_en %b exp 0", bus.run_en); end
                    end
                end else if (p == 1 && tr != 0 && i == tr + 1) begin
                    checks++;
                    if (bus.run_en !== 1'b1) begin errors++; $display("FAIL run_en_rise got %b exp 1", bus.run_en); end
                end
            end
            checks++;
            if (tr != D || bus.cpustate !== 2'(exp_state)) begin
                errors++; $display("FAIL cycle_step p %0d got edge %0d st %b exp edge %0d st %0d", p, tr, bus.cpustate, D, exp_state);
            end
            bus.key_mode_n = 1'b1;
            repeat (D + 2) begin
                tick(); checks++;
                if (dut_vec() !== m_vec) begin errors++; $display("FAIL cycle_rel_vec got %b exp %b", dut_vec(), m_vec); end
            end
        end
    endtask

    task automatic test_halt();
        repeat (3) press_mode_quiet();
        repeat (2) tick();
        checks++;
        if (bus.cpustate !== 2'b11 || bus.run_en !== 1'b1) begin
            errors++; $display("FAIL halt_pre got st %b run %b exp 11 1", bus.cpustate, bus.run_en);
        end
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.run_en !== 1'b0 || bus.cpustate !== 2'b11 || dut_vec() !== m_vec) begin
                errors++; $display("FAIL halt_hold cyc %0d got %b exp %b", i, dut_vec(), m_vec);
            end
            tick();
        end
        press_mode_quiet();
        checks++;
        if (dut_vec() !== m_vec || bus.cpustate !== 2'b00) begin
            errors++; $display("FAIL halt_exit got %b exp %b", dut_vec(), m_vec);
        end
    endtask

    task automatic test_step_across_mode();
        int falls;
        logic prev, exp_s;
        press_mode_quiet();
        bus.key_step_n = 1'b0;
        repeat (D + 3) tick();
        checks++;
        if (bus.step_n !== 1'b0 || bus.cpustate !== 2'b01) begin
            errors++; $display("FAIL held_pre got step %b st %b exp 0 01", bus.step_n, bus.cpustate);
        end
        bus.key_mode_n = 1'b0;
        prev  = bus.step_n;
        falls = 0;
        for (int i = 1; i <= D + 4; i++) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL held_vec cyc %0d got %b exp %b", i, dut_vec(), m_vec); end
            exp_s = (i == D || i == D + 1);
            checks++;
            if (bus.step_n !== exp_s) begin errors++; $display("FAIL held_mask cyc %0d got %b exp %b", i, bus.step_n, exp_s); end
            if (prev == 1'b1 && bus.step_n == 1'b0 && bus.cpustate == 2'b10) falls++;
            prev = bus.step_n;
        end
        bus.key_mode_n = 1'b1;
        bus.key_step_n = 1'b1;
        repeat (D + 2) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL held_rel_vec got %b exp %b", dut_vec(), m_vec); end
            if (prev == 1'b1 && bus.step_n == 1'b0 && bus.cpustate == 2'b10) falls++;
            prev = bus.step_n;
        end
        checks++;
        if (falls != 1 || bus.cpustate !== 2'b10) begin
            errors++; $display("FAIL held_falls got %0d st %b exp 1 10", falls, bus.cpustate);
        end
    endtask

    task automatic test_reset_mid();
        bus.key_mode_n = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick(); checks++;
        if (dut_vec() !== m_vec || bus.cpustate !== 2'b00) begin
            errors++; $display("FAIL mid_reset got %b exp %b", dut_vec(), m_vec);
        end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL mid_vec cyc %0d got %b exp %b", i, dut_vec(), m_vec); end
            if (i == 3) begin
                checks++;
                if (bus.cpustate !== 2'b00) begin errors++; $display("FAIL mid_pending got %b exp 00", bus.cpustate); end
            end
        end
        checks++;
        if (bus.cpustate !== 2'b01) begin errors++; $display("FAIL mid_restart got %b exp 01", bus.cpustate); end
        bus.key_mode_n = 1'b1;
        repeat (D + 2) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) bus.key_mode_n = ~bus.key_mode_n;
            if ($urandom_range(5) == 0) bus.key_step_n = ~bus.key_step_n;
            bus.cpu_halt = ($urandom_range(15) == 0);
            reset        = ($urandom_range(399) == 0);
            tick(); checks++;
            if (dut_vec() !== m_vec) begin errors++; $display("FAIL random_vec cyc %0d got %b exp %b", i, dut_vec(), m_vec); end
        end
        reset        = 1'b0;
        bus.cpu_halt = 1'b0;
    endtask

    initial begin
        bus.key_mode_n = 1'b1;
        bus.key_step_n = 1'b1;
        bus.cpu_halt   = 1'b0;
        test_reset();
        test_debounce_mode();
        test_step();
        test_mode_cycle();
        test_halt();
        test_step_across_mode();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
